// File: rtl/spi_gen_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, SPI mode constants
// ({cpol,cpha}) and the frame-length field width helper.
package spi_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } spi_state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Length field must hold DATA_W itself, hence one bit more than an index.
  function automatic int unsigned len_w(input int unsigned data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period tick generator: while enabled, pulses o_tick once every
// i_reload+1 cycles; while disabled it holds the reload value ready.
module spi_clkgen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_reload,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (!i_en || r_cnt == '0) r_cnt <= i_reload;
    else                          r_cnt <= r_cnt - DIV_W'(1);
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/spi_master_gen.sv
// Generic SPI master (modes 0-3, MSB/LSB first, variable frame length).
// Define SPI_MASTER_GEN_LOOPBACK_EN to let the loopback port route MOSI to the receiver.
module spi_master_gen
  import spi_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 16
) (
  input  logic                  clk_cpu,
  input  logic                  rst,
  input  logic [DIV_W-1:0]      SPI_BITRATE,
  input  logic [DATA_W-1:0]     SPI_DATA_OUT,
  output logic [DATA_W-1:0]     SPI_DATA_IN,
  input  logic                  start,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [$clog2(DATA_W):0] len,
  input  logic [2:0]            ss_sel,
  input  logic                  irq_en,
  input  logic                  irq_clr,
  input  logic                  loopback,
  output logic                  busy,
  output logic                  done,
  output logic                  SCK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic [NUM_SS-1:0]     SS,
  output logic                  IRQ_SPI
);

  localparam int LEN_W = len_w(DATA_W);
  localparam int IDX_W = LEN_W - 1;

  spi_state_t         r_state;
  logic [DIV_W-1:0]   r_bitrate;
  logic [DATA_W-1:0]  r_tx, r_rx, r_data_in;
  logic [LEN_W-1:0]   r_len, r_bit;
  logic [NUM_SS-1:0]  r_ss;
  logic               r_cpol, r_cpha, r_lsb, r_lead, r_arm;
  logic               r_sck, r_mosi, r_done, r_irq;

  logic [LEN_W-1:0]   w_len_in;
  logic [IDX_W-1:0]   w_pos0, w_pos_cur, w_pos_next;
  logic [NUM_SS-1:0]  w_ss_act;
  logic [DIV_W-1:0]   w_reload;
  logic [1:0]         w_mode;
  logic               w_en, w_tick, w_miso, w_lead_sample;

  function automatic logic [IDX_W-1:0] f_pos(input logic lsb,
                                             input logic [LEN_W-1:0] l,
                                             input logic [LEN_W-1:0] b);
    logic [LEN_W-1:0] p;
    p = lsb ? b : (l - LEN_W'(1) - b);
    return p[IDX_W-1:0];
  endfunction

  assign w_len_in   = (len == '0 || len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len;
  assign w_pos0     = f_pos(lsb_first, w_len_in, '0);
  assign w_pos_cur  = f_pos(r_lsb, r_len, r_bit);
  assign w_pos_next = f_pos(r_lsb, r_len, r_bit + LEN_W'(1));
  assign w_mode     = {r_cpol, r_cpha};

  always_comb begin
    w_lead_sample = 1'b1;
    case (w_mode)
      SPI_MODE0, SPI_MODE2: w_lead_sample = 1'b1;
      SPI_MODE1, SPI_MODE3: w_lead_sample = 1'b0;
      default:              w_lead_sample = 1'b1;
    endcase
  end

  always_comb begin
    w_ss_act = '1;
    for (int unsigned i = 0; i < unsigned'(NUM_SS); i++)
      if (ss_sel == 3'(i)) w_ss_act[i] = 1'b0;
  end

`ifdef SPI_MASTER_GEN_LOOPBACK_EN
  assign w_miso = loopback ? r_mosi : MISO;
`else
  logic w_unused_loopback;
  assign w_unused_loopback = loopback;
  assign w_miso = MISO;
`endif

  // In IDLE the divider preloads from the live input so SETUP starts on the new rate.
  assign w_reload = (r_state == ST_IDLE) ? SPI_BITRATE : r_bitrate;
  assign w_en     = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk      (clk_cpu),
    .rst_n    (rst),
    .i_en     (w_en),
    .i_reload (w_reload),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_bitrate <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_data_in <= '0;
      r_len     <= '0;
      r_bit     <= '0;
      r_ss      <= '1;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
      r_lead    <= 1'b1;
      r_arm     <= 1'b0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_done    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_arm  <= 1'b1;
      r_done <= 1'b0;
      if (r_state == ST_DONE && irq_en) r_irq <= 1'b1;
      else if (irq_clr)                 r_irq <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_sck <= cpol;
          if (start && r_arm) begin
            r_bitrate <= SPI_BITRATE;
            r_tx      <= SPI_DATA_OUT;
            r_cpol    <= cpol;
            r_cpha    <= cpha;
            r_lsb     <= lsb_first;
            r_len     <= w_len_in;
            r_bit     <= '0;
            r_lead    <= 1'b1;
            r_rx      <= '0;
            r_ss      <= w_ss_act;
            if (!cpha) r_mosi <= SPI_DATA_OUT[w_pos0];
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: if (w_tick) r_state <= ST_SHIFT;
        ST_SHIFT: if (w_tick) begin
          r_sck  <= ~r_sck;
          r_lead <= ~r_lead;
          if (r_lead) begin
            if (w_lead_sample) r_rx[w_pos_cur] <= w_miso;
            else               r_mosi <= r_tx[w_pos_cur];
          end else begin
            if (!w_lead_sample) r_rx[w_pos_cur] <= w_miso;
            if (r_bit == r_len - LEN_W'(1)) begin
              r_state <= ST_HOLD;
            end else begin
              r_bit <= r_bit + LEN_W'(1);
              if (w_lead_sample) r_mosi <= r_tx[w_pos_next];
            end
          end
        end
        ST_HOLD: if (w_tick) begin
          r_state   <= ST_DONE;
          r_ss      <= '1;
          r_data_in <= r_rx;
          r_done    <= 1'b1;
        end
        ST_DONE: begin
          r_sck   <= r_cpol;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign SCK         = r_sck;
  assign MOSI        = r_mosi;
  assign SS          = r_ss;
  assign IRQ_SPI     = r_irq;
  assign SPI_DATA_IN = r_data_in;

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed self-checking bench for spi_master_gen (default parameters).
module tb_spi_master_gen;

  logic        clk_cpu = 1'b0;
  logic        rst;
  logic [15:0] SPI_BITRATE;
  logic [31:0] SPI_DATA_OUT, SPI_DATA_IN;
  logic        start, cpol, cpha, lsb_first;
  logic [5:0]  len;
  logic [2:0]  ss_sel;
  logic        irq_en, irq_clr, loopback;
  logic        busy, done, SCK, MOSI, MISO, IRQ_SPI;
  logic [3:0]  SS;

  always #5 clk_cpu = ~clk_cpu;

  spi_master_gen #(.DATA_W(32), .NUM_SS(4), .DIV_W(16)) dut (
    .clk_cpu(clk_cpu), .rst(rst), .SPI_BITRATE(SPI_BITRATE),
    .SPI_DATA_OUT(SPI_DATA_OUT), .SPI_DATA_IN(SPI_DATA_IN),
    .start(start), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .len(len), .ss_sel(ss_sel), .irq_en(irq_en), .irq_clr(irq_clr),
    .loopback(loopback), .busy(busy), .done(done), .SCK(SCK),
    .MOSI(MOSI), .MISO(MISO), .SS(SS), .IRQ_SPI(IRQ_SPI)
  );

`ifdef SPI_MASTER_GEN_LOOPBACK_EN
  localparam logic [31:0] EXP_LB = 32'h8000_0001;
`else
  localparam logic [31:0] EXP_LB = 32'h0000_0000;
`endif

  int n_chk = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Slave/bus monitor: free-running counters, frames snapshot bases.
  int          n_lead = 0, n_trail = 0, ss_bad = 0, n_done = 0;
  int          lead_base = 0, trail_base = 0, ss_base = 0, slv_top = 0, slv_pos;
  logic [63:0] mosi_bits = '0;
  logic [31:0] slv_word = '0;
  logic [3:0]  exp_ss = '1;
  logic        prev_sck = 1'b0;

  always @(negedge clk_cpu) begin
    if (busy && SCK !== prev_sck) begin
      if (SCK !== cpol) begin
        mosi_bits[n_lead[5:0]] = MOSI;
        n_lead++;
        if (SS !== exp_ss) ss_bad++;
      end else begin
        n_trail++;
      end
    end
    if (done) n_done++;
    prev_sck = SCK;
  end

  assign slv_pos = slv_top - (n_trail - trail_base);
  always_comb begin
    MISO = 1'b0;
    if (slv_pos >= 0 && slv_pos < 32) MISO = slv_word[slv_pos[4:0]];
  end

  function automatic logic [31:0] mosi_word(input int n, input logic lsb);
    logic [31:0] w;
    int idx;
    w = '0;
    for (int i = 0; i < n; i++) begin
      idx = lead_base + i;
      if (lsb) w[i] = mosi_bits[idx[5:0]];
      else     w = {w[30:0], mosi_bits[idx[5:0]]};
    end
    return w;
  endfunction

  task automatic setup_frame(input logic p_cpol, input logic p_cpha, input logic p_lsb,
                             input logic [5:0] p_len, input logic [31:0] p_data,
                             input logic [15:0] p_br, input logic [2:0] p_sel,
                             input logic [31:0] p_slv, input logic [3:0] p_ss);
    cpol = p_cpol; cpha = p_cpha; lsb_first = p_lsb; len = p_len;
    SPI_DATA_OUT = p_data; SPI_BITRATE = p_br; ss_sel = p_sel;
    slv_word = p_slv; exp_ss = p_ss;
    slv_top = (p_len == 0) ? 31 : int'(p_len) - 1;
    trail_base = n_trail; lead_base = n_lead; ss_base = ss_bad;
  endtask

  task automatic run_frame(output int lat);
    @(posedge clk_cpu); #1; start = 1'b1;
    @(posedge clk_cpu); #1; start = 1'b0;
    lat = 1;
    while (!done && lat < 500) begin
      @(posedge clk_cpu); #1;
      lat++;
    end
  endtask

  int lat, nd0;

  initial begin
    rst = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    len = '0; ss_sel = '0; irq_en = 1'b0; irq_clr = 1'b0; loopback = 1'b0;
    SPI_BITRATE = '0; SPI_DATA_OUT = '0;
    repeat (2) @(posedge clk_cpu); #1;
    check_eq("rst_ss",   32'(SS), 32'hF);
    check_eq("rst_sck",  32'(SCK), 0);
    check_eq("rst_mosi", 32'(MOSI), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_irq",  32'(IRQ_SPI), 0);
    check_eq("rst_din",  SPI_DATA_IN, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk_cpu);

    // Mode 0, MSB first, 8 bits, H=2
    setup_frame(0, 0, 0, 6'd8, 32'hA9, 16'd1, 3'd0, 32'h5C, 4'b1110);
    run_frame(lat);
    check_eq("t1_latency", 32'(lat), 37);
    check_eq("t1_busy_in_done", 32'(busy), 1);
    check_eq("t1_ss_in_done", 32'(SS), 32'hF);
    check_eq("t1_din", SPI_DATA_IN, 32'h0000_005C);
    check_eq("t1_mosi", mosi_word(8, 0), 32'hA9);
    check_eq("t1_pulses", 32'(n_lead - lead_base), 8);
    check_eq("t1_ss_low", 32'(ss_bad - ss_base), 0);
    @(posedge clk_cpu); #1;
    check_eq("t1_done_1cyc", 32'(done), 0);
    check_eq("t1_idle", 32'(busy), 0);
    check_eq("t1_no_irq", 32'(IRQ_SPI), 0);

    // Mode 3, LSB first, 4 bits, H=1
    setup_frame(1, 1, 1, 6'd4, 32'h3, 16'd0, 3'd2, 32'h0, 4'b1011);
    repeat (2) @(posedge clk_cpu); #1;
    check_eq("t2_sck_idle", 32'(SCK), 1);
    run_frame(lat);
    check_eq("t2_latency", 32'(lat), 11);
    check_eq("t2_mosi", mosi_word(4, 1), 32'h3);
    check_eq("t2_pulses", 32'(n_lead - lead_base), 4);
    check_eq("t2_ss_low", 32'(ss_bad - ss_base), 0);
    check_eq("t2_din", SPI_DATA_IN, 0);

    // len=0 means full width; loopback with MISO held low
    loopback = 1'b1; irq_en = 1'b1;
    setup_frame(0, 0, 0, 6'd0, 32'h8000_0001, 16'd0, 3'd0, 32'h0, 4'b1110);
    run_frame(lat);
    check_eq("t3_latency", 32'(lat), 67);
    check_eq("t3_din", SPI_DATA_IN, EXP_LB);
    check_eq("t3_mosi", mosi_word(32, 0), 32'h8000_0001);
    @(posedge clk_cpu); #1;
    check_eq("t3_irq_set", 32'(IRQ_SPI), 1);
    repeat (5) @(posedge clk_cpu); #1;
    check_eq("t3_irq_sticky", 32'(IRQ_SPI), 1);
    loopback = 1'b0;

    // Mid-frame start pulse and input changes must not disturb the frame
    setup_frame(0, 0, 0, 6'd8, 32'h3C, 16'd1, 3'd3, 32'hA5, 4'b0111);
    nd0 = n_done;
    fork
      run_frame(lat);
      begin
        repeat (10) @(posedge clk_cpu); #2;
        start = 1'b1; SPI_BITRATE = 16'd5; SPI_DATA_OUT = 32'hFF; len = 6'd3;
        @(posedge clk_cpu); #2;
        start = 1'b0;
      end
    join
    check_eq("t4_latency", 32'(lat), 37);
    check_eq("t4_din", SPI_DATA_IN, 32'hA5);
    check_eq("t4_mosi", mosi_word(8, 0), 32'h3C);
    repeat (60) @(posedge clk_cpu); #1;
    check_eq("t4_one_done", 32'(n_done - nd0), 1);
    check_eq("t4_no_requeue", 32'(busy), 0);

    // Asynchronous reset mid-SHIFT, then recovery (mode 2)
    setup_frame(1, 0, 0, 6'd8, 32'h96, 16'd3, 3'd1, 32'h0, 4'b1101);
    @(posedge clk_cpu); #1; start = 1'b1;
    @(posedge clk_cpu); #1; start = 1'b0;
    repeat (20) @(posedge clk_cpu); #3;
    check_eq("t5_busy_pre", 32'(busy), 1);
    check_eq("t5_ss_pre", 32'(SS), 32'hD);
    rst = 1'b0; #1;
    check_eq("t5_rst_ss", 32'(SS), 32'hF);
    check_eq("t5_rst_sck", 32'(SCK), 0);
    check_eq("t5_rst_busy", 32'(busy), 0);
    check_eq("t5_rst_done", 32'(done), 0);
    check_eq("t5_rst_mosi", 32'(MOSI), 0);
    check_eq("t5_rst_din", SPI_DATA_IN, 0);
    check_eq("t5_rst_irq", 32'(IRQ_SPI), 0);
    irq_en = 1'b0;
    setup_frame(1, 0, 0, 6'd8, 32'h96, 16'd1, 3'd1, 32'h69, 4'b1101);
    start = 1'b1;
    @(posedge clk_cpu); #1; rst = 1'b1;
    @(posedge clk_cpu); #1;
    check_eq("t5_first_edge", 32'(busy), 0);
    @(posedge clk_cpu); #1;
    check_eq("t5_second_edge", 32'(busy), 1);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 500) begin
      @(posedge clk_cpu); #1;
      lat++;
    end
    check_eq("t5_latency", 32'(lat), 37);
    check_eq("t5_din", SPI_DATA_IN, 32'h69);
    check_eq("t5_mosi", mosi_word(8, 0), 32'h96);
    check_eq("t5_ss_low", 32'(ss_bad - ss_base), 0);

    // Out-of-range slave select; IRQ set wins over a held clear
    irq_en = 1'b1; irq_clr = 1'b1;
    setup_frame(0, 0, 0, 6'd8, 32'h5A, 16'd0, 3'd5, 32'h0, 4'hF);
    run_frame(lat);
    check_eq("t6_latency", 32'(lat), 19);
    check_eq("t6_ss_high", 32'(ss_bad - ss_base), 0);
    check_eq("t6_pulses", 32'(n_lead - lead_base), 8);
    check_eq("t6_mosi", mosi_word(8, 0), 32'h5A);
    @(posedge clk_cpu); #1;
    check_eq("t6_irq_set_wins", 32'(IRQ_SPI), 1);
    @(posedge clk_cpu); #1;
    check_eq("t6_irq_clr", 32'(IRQ_SPI), 0);
    irq_clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
